caliptra_tlul_socket_m1_rr: RTL and testbench

M:1 TL-UL host-merge socket with round-robin arbitration. It sits directly downstream of the 1:N device-steering sockets in the crossbar: each host's per-device branch lands here, and one merged TL-UL port drives the device (or its device-side FIFO). The host index is encoded into the low bits of `a_source`, and responses are routed back by decoding those bits. A one-entry registered request slice and an outstanding-transaction limiter give the block its sequential behaviour.

---
 rtl/caliptra_tlul_socket_m1_rr.sv | 175 +++++++++++++++++
 tb/tb_caliptra_tlul_socket_m1_rr.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/caliptra_tlul_socket_m1_rr.sv
// M:1 TL-UL host-merge socket: round-robin arbitration into a one-entry request slice,
// host ID tagged into a_source, combinational response routing and an in-flight limiter.

package caliptra_tlul_pkg;

  localparam int unsigned TL_AW  = 32;
  localparam int unsigned TL_DW  = 32;
  localparam int unsigned TL_AIW = 8;
  localparam int unsigned TL_DIW = 1;
  localparam int unsigned TL_DBW = TL_DW / 8;
  localparam int unsigned TL_SZW = $clog2($clog2(TL_DBW) + 1);

  typedef enum logic [2:0] {
    PutFullData    = 3'h0,
    PutPartialData = 3'h1,
    Get            = 3'h4
  } tl_a_op_e;

  typedef enum logic [2:0] {
    AccessAck     = 3'h0,
    AccessAckData = 3'h1
  } tl_d_op_e;

  typedef struct packed {
    logic [4:0] rsvd;
    logic [3:0] instr_type;
    logic [6:0] cmd_intg;
    logic [6:0] data_intg;
  } tl_a_user_t;

  typedef struct packed {
    logic [6:0] rsp_intg;
    logic [6:0] data_intg;
  } tl_d_user_t;

  typedef struct packed {
    logic                a_valid;
    tl_a_op_e            a_opcode;
    logic [2:0]          a_param;
    logic [TL_SZW-1:0]   a_size;
    logic [TL_AIW-1:0]   a_source;
    logic [TL_AW-1:0]    a_address;
    logic [TL_DBW-1:0]   a_mask;
    logic [TL_DW-1:0]    a_data;
    tl_a_user_t          a_user;
    logic                d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic                d_valid;
    tl_d_op_e            d_opcode;
    logic [2:0]          d_param;
    logic [TL_SZW-1:0]   d_size;
    logic [TL_AIW-1:0]   d_source;
    logic [TL_DIW-1:0]   d_sink;
    logic [TL_DW-1:0]    d_data;
    tl_d_user_t          d_user;
    logic                d_error;
    logic                a_ready;
  } tl_d2h_t;

endpackage

module caliptra_tlul_socket_m1_rr
  import caliptra_tlul_pkg::*;
#(
  parameter int unsigned M              = 2,
  parameter int unsigned MaxOutstanding = 16,
  localparam int unsigned StIdW         = $clog2(M),
  localparam int unsigned CntW          = $clog2(MaxOutstanding + 1)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  tl_h2d_t         tl_h_i [M],
  output tl_d2h_t         tl_h_o [M],
  output tl_h2d_t         tl_d_o,
  input  tl_d2h_t         tl_d_i,
  output logic [CntW-1:0] outstanding_o,
  output logic            drop_rsp_o
);

  localparam logic [StIdW-1:0] LastId   = StIdW'(M - 1);
  localparam logic [StIdW:0]   NumHosts = (StIdW + 1)'(M);
  localparam logic [CntW-1:0]  MaxCnt   = CntW'(MaxOutstanding);

  tl_h2d_t          slice_q;
  logic             slice_vld_q;
  logic [StIdW-1:0] ptr_q;
  logic [CntW-1:0]  cnt_q;

  logic             win_vld;
  logic [StIdW-1:0] win_idx;
  logic [StIdW-1:0] scan_idx;
  tl_h2d_t          win_req;
  logic             slice_free;
  logic             gnt;

  logic [StIdW-1:0] rsp_id;
  logic             rsp_legal;
  logic             rsp_ready;
  logic             d_hs;

  // First requester at or after ptr_q, wrapping modulo M.
  always_comb begin
    win_vld  = 1'b0;
    win_idx  = ptr_q;
    scan_idx = '0;
    for (int unsigned i = 0; i < M; i++) begin
      scan_idx = StIdW'((32'(ptr_q) + i) % M);
      if (!win_vld && tl_h_i[scan_idx].a_valid) begin
        win_vld = 1'b1;
        win_idx = scan_idx;
      end
    end
  end

  always_comb begin
    win_req          = tl_h_i[win_idx];
    win_req.a_source = {tl_h_i[win_idx].a_source[TL_AIW-StIdW-1:0], win_idx};
  end

  // The slice may be refilled in the same cycle its current entry is dequeued.
  assign slice_free = ~slice_vld_q | tl_d_i.a_ready;
  assign gnt        = rst_ni & win_vld & slice_free & (cnt_q < MaxCnt);

  assign rsp_id    = tl_d_i.d_source[StIdW-1:0];
  assign rsp_legal = {1'b0, rsp_id} < NumHosts;

  always_comb begin
    rsp_ready = 1'b1;
    for (int unsigned k = 0; k < M; k++) begin
      tl_h_o[k]          = tl_d_i;
      tl_h_o[k].d_source = tl_d_i.d_source >> StIdW;
      tl_h_o[k].d_valid  = tl_d_i.d_valid & rsp_legal & (rsp_id == StIdW'(k));
      tl_h_o[k].a_ready  = gnt & (win_idx == StIdW'(k));
      if (rsp_legal && (rsp_id == StIdW'(k))) begin
        rsp_ready = tl_h_i[k].d_ready;
      end
    end
  end

  always_comb begin
    tl_d_o         = slice_q;
    tl_d_o.a_valid = slice_vld_q;
    tl_d_o.d_ready = rsp_ready;
  end

  assign d_hs          = tl_d_i.d_valid & rsp_ready;
  assign drop_rsp_o    = rst_ni & tl_d_i.d_valid & ~rsp_legal;
  assign outstanding_o = cnt_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      slice_q     <= '0;
      slice_vld_q <= 1'b0;
      ptr_q       <= '0;
      cnt_q       <= '0;
    end else begin
      if (gnt) begin
        slice_q     <= win_req;
        slice_vld_q <= 1'b1;
        ptr_q       <= (win_idx == LastId) ? '0 : win_idx + 1'b1;
      end else if (tl_d_i.a_ready) begin
        slice_vld_q <= 1'b0;
      end

      if (gnt && !d_hs) begin
        cnt_q <= cnt_q + 1'b1;
      end else if (!gnt && d_hs && (cnt_q != '0)) begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_caliptra_tlul_socket_m1_rr.sv
// Directed bench for caliptra_tlul_socket_m1_rr: three instances cover M=3 arbitration and
// illegal IDs, M=4 response routing, and an M=2 socket with an outstanding limit of 2.
module tb_caliptra_tlul_socket_m1_rr;
  import caliptra_tlul_pkg::*;

  logic clk = 1'b0;
  logic rst3;
  logic rst_n;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  tl_h2d_t    h3_i [3];
  tl_d2h_t    h3_o [3];
  tl_h2d_t    d3_o;
  tl_d2h_t    d3_i;
  logic [4:0] out3;
  logic       drop3;

  tl_h2d_t    h4_i [4];
  tl_d2h_t    h4_o [4];
  tl_h2d_t    d4_o;
  tl_d2h_t    d4_i;
  logic [4:0] out4;
  logic       drop4;

  tl_h2d_t    hl_i [2];
  tl_d2h_t    hl_o [2];
  tl_h2d_t    dl_o;
  tl_d2h_t    dl_i;
  logic [1:0] outl;
  logic       dropl;

  caliptra_tlul_socket_m1_rr #(.M(3), .MaxOutstanding(16)) u_m3 (
    .clk_i(clk), .rst_ni(rst3), .tl_h_i(h3_i), .tl_h_o(h3_o),
    .tl_d_o(d3_o), .tl_d_i(d3_i), .outstanding_o(out3), .drop_rsp_o(drop3)
  );

  caliptra_tlul_socket_m1_rr #(.M(4), .MaxOutstanding(16)) u_m4 (
    .clk_i(clk), .rst_ni(rst_n), .tl_h_i(h4_i), .tl_h_o(h4_o),
    .tl_d_o(d4_o), .tl_d_i(d4_i), .outstanding_o(out4), .drop_rsp_o(drop4)
  );

  caliptra_tlul_socket_m1_rr #(.M(2), .MaxOutstanding(2)) u_lim (
    .clk_i(clk), .rst_ni(rst_n), .tl_h_i(hl_i), .tl_h_o(hl_o),
    .tl_d_o(dl_o), .tl_d_i(dl_i), .outstanding_o(outl), .drop_rsp_o(dropl)
  );

  logic [2:0] ar3_v, dv3_v;
  logic [3:0] dv4_v;
  logic [1:0] arl_v;
  assign ar3_v = {h3_o[2].a_ready, h3_o[1].a_ready, h3_o[0].a_ready};
  assign dv3_v = {h3_o[2].d_valid, h3_o[1].d_valid, h3_o[0].d_valid};
  assign dv4_v = {h4_o[3].d_valid, h4_o[2].d_valid, h4_o[1].d_valid, h4_o[0].d_valid};
  assign arl_v = {hl_o[1].a_ready, hl_o[0].a_ready};

  // Host ID bits of a_source must be free, and the in-flight count may never leave its range.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++)
      assert (!(h3_i[k].a_valid && h3_i[k].a_source[7:6] != 2'b00)) else $error("m3 host a_source id bits set");
    for (int k = 0; k < 4; k++)
      assert (!(h4_i[k].a_valid && h4_i[k].a_source[7:6] != 2'b00)) else $error("m4 host a_source id bits set");
    for (int k = 0; k < 2; k++)
      assert (!(hl_i[k].a_valid && hl_i[k].a_source[7] != 1'b0)) else $error("lim host a_source id bit set");
    assert (out3 <= 5'd16 && out4 <= 5'd16 && outl <= 2'd2) else $error("outstanding counter out of range");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic tl_h2d_t mkreq(input int unsigned k, input logic vld);
    tl_h2d_t r;
    r           = '0;
    r.a_valid   = vld;
    r.a_opcode  = Get;
    r.a_size    = 2'd2;
    r.a_source  = 8'(32'h10 + k);
    r.a_address = 32'h4000_0000 + 32'(k * 4);
    r.a_mask    = '1;
    r.a_data    = 32'hD000_0000 + 32'(k);
    r.d_ready   = 1'b1;
    return r;
  endfunction

  typedef struct {
    logic [7:0] dsrc;
    logic       dvld;
    logic [3:0] hrdy;
    logic [3:0] exp_vld;
    logic [7:0] exp_src;
    logic       exp_drdy;
  } rsp_vec_t;

  rsp_vec_t   vecs [6];
  logic [7:0] tag3 [3];

  initial begin
    // M=4 routing: {d_source, d_valid, host d_ready} -> {host d_valid, host d_source, device d_ready}
    vecs[0] = '{8'h1E, 1'b1, 4'b1111, 4'b0100, 8'h07, 1'b1};
    vecs[1] = '{8'h1E, 1'b1, 4'b1011, 4'b0100, 8'h07, 1'b0};
    vecs[2] = '{8'h00, 1'b1, 4'b1111, 4'b0001, 8'h00, 1'b1};
    vecs[3] = '{8'hFF, 1'b1, 4'b0111, 4'b1000, 8'h3F, 1'b0};
    vecs[4] = '{8'h05, 1'b0, 4'b1111, 4'b0000, 8'h01, 1'b1};
    vecs[5] = '{8'h81, 1'b1, 4'b1101, 4'b0010, 8'h20, 1'b0};
    // Host k sends a_source 0x10+k; tagged as {src[5:0], k}.
    tag3[0] = 8'h40;
    tag3[1] = 8'h45;
    tag3[2] = 8'h4A;

    rst3  = 1'b0;
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) h3_i[k] = mkreq(k, 1'b1);
    for (int k = 0; k < 4; k++) h4_i[k] = mkreq(k, 1'b0);
    for (int k = 0; k < 2; k++) hl_i[k] = mkreq(k, 1'b0);
    d3_i = '0; d3_i.a_ready = 1'b1;
    d4_i = '0; d4_i.a_ready = 1'b1;
    dl_i = '0; dl_i.a_ready = 1'b1;

    // Reset state
    #1;
    check("rst_gate_ready", ar3_v, 3'b000);
    tick();
    check("rst_avalid", d3_o.a_valid, 1'b0);
    check("rst_cnt3", out3, 5'd0);
    check("rst_drop", drop3, 1'b0);
    check("rst_cntl", outl, 2'd0);
    check("rst_gate_ready2", ar3_v, 3'b000);
    tick();
    rst3  = 1'b1;
    rst_n = 1'b1;
    #1;

    // Fairness: all three hosts request, device always ready
    for (int i = 0; i < 6; i++) begin
      check("fair_ready", ar3_v, 3'b001 << (i % 3));
      check("fair_cnt", out3, 5'(i));
      if (i > 0) begin
        check("fair_avalid", d3_o.a_valid, 1'b1);
        check("fair_tag", d3_o.a_source, tag3[(i - 1) % 3]);
      end
      tick();
    end
    check("fair_tag_last", d3_o.a_source, tag3[2]);
    check("fair_cnt_last", out3, 5'd6);

    // Backpressure: host 1 granted, device stalls 5 cycles, then host 2 goes straight in
    for (int k = 0; k < 3; k++) h3_i[k].a_valid = 1'b0;
    tick();
    check("bp_drained", d3_o.a_valid, 1'b0);
    h3_i[1].a_valid = 1'b1;
    h3_i[2].a_valid = 1'b1;
    #1;
    check("bp_grant1", ar3_v, 3'b010);
    tick();
    h3_i[1].a_valid = 1'b0;
    d3_i.a_ready    = 1'b0;
    #1;
    for (int c = 0; c < 5; c++) begin
      check("bp_hold_valid", d3_o.a_valid, 1'b1);
      check("bp_hold_src", d3_o.a_source, 8'h45);
      check("bp_hold_data", d3_o.a_data, 32'hD000_0001);
      check("bp_no_grant", ar3_v, 3'b000);
      tick();
    end
    d3_i.a_ready = 1'b1;
    #1;
    check("bp_grant2", ar3_v, 3'b100);
    tick();
    h3_i[2].a_valid = 1'b0;
    check("bp_src2", d3_o.a_source, 8'h4A);
    check("bp_cnt", out3, 5'd8);

    // Illegal ID 3 on M=3 is dropped but still consumed
    d3_i.d_valid  = 1'b1;
    d3_i.d_source = 8'h03;
    #1;
    check("ill_drop", drop3, 1'b1);
    check("ill_dready", d3_o.d_ready, 1'b1);
    check("ill_no_dvalid", dv3_v, 3'b000);
    tick();
    check("ill_cnt", out3, 5'd7);
    d3_i.d_source = 8'h05;
    #1;
    check("rsp3_dvalid", dv3_v, 3'b010);
    check("rsp3_src", h3_o[1].d_source, 8'h01);
    check("rsp3_nodrop", drop3, 1'b0);
    tick();
    d3_i.d_valid = 1'b0;
    check("rsp3_cnt", out3, 5'd6);

    // Reset with the slice full discards it and restores ptr to 0
    d3_i.a_ready    = 1'b0;
    h3_i[0].a_valid = 1'b1;
    #1;
    check("fill_grant0", ar3_v, 3'b001);
    tick();
    check("fill_valid", d3_o.a_valid, 1'b1);
    check("fill_cnt", out3, 5'd7);
    rst3            = 1'b0;
    h3_i[1].a_valid = 1'b1;
    #1;
    check("mid_rst_gate", ar3_v, 3'b000);
    tick();
    check("mid_rst_valid", d3_o.a_valid, 1'b0);
    check("mid_rst_cnt", out3, 5'd0);
    rst3         = 1'b1;
    d3_i.a_ready = 1'b1;
    #1;
    check("mid_rst_ptr", ar3_v, 3'b001);
    tick();
    for (int k = 0; k < 3; k++) h3_i[k].a_valid = 1'b0;

    // M=4 response routing table
    for (int i = 0; i < 6; i++) begin
      for (int k = 0; k < 4; k++) h4_i[k].d_ready = vecs[i].hrdy[k];
      d4_i.d_source = vecs[i].dsrc;
      d4_i.d_valid  = vecs[i].dvld;
      d4_i.d_data   = 32'hCAFE_0000 + 32'(i);
      #1;
      check("rt_dvalid", dv4_v, vecs[i].exp_vld);
      check("rt_dsource", h4_o[0].d_source, vecs[i].exp_src);
      check("rt_dready", d4_o.d_ready, vecs[i].exp_drdy);
      check("rt_ddata", h4_o[3].d_data, 32'hCAFE_0000 + 32'(i));
      check("rt_nodrop", drop4, 1'b0);
    end
    d4_i.d_valid = 1'b0;

    // Limiter: MaxOutstanding=2
    hl_i[0].a_valid = 1'b1;
    hl_i[1].a_valid = 1'b1;
    #1;
    check("lim_g0", arl_v, 2'b01);
    check("lim_c0", outl, 2'd0);
    tick();
    check("lim_g1", arl_v, 2'b10);
    check("lim_c1", outl, 2'd1);
    tick();
    check("lim_stop", arl_v, 2'b00);
    check("lim_c2", outl, 2'd2);
    tick();
    check("lim_stop2", arl_v, 2'b00);
    check("lim_c2b", outl, 2'd2);
    dl_i.d_valid  = 1'b1;
    dl_i.d_source = 8'h02;
    #1;
    check("lim_rsp_dready", dl_o.d_ready, 1'b1);
    check("lim_rsp_nogrant", arl_v, 2'b00);
    tick();
    dl_i.d_valid = 1'b0;
    #1;
    check("lim_c_after_rsp", outl, 2'd1);
    check("lim_g2", arl_v, 2'b01);
    tick();
    check("lim_c_full", outl, 2'd2);
    check("lim_stop3", arl_v, 2'b00);

    // Simultaneous grant and response at count 1
    hl_i[0].a_valid = 1'b0;
    hl_i[1].a_valid = 1'b0;
    dl_i.d_valid    = 1'b1;
    dl_i.d_source   = 8'h03;
    tick();
    check("sim_c1", outl, 2'd1);
    hl_i[1].a_valid = 1'b1;
    #1;
    check("sim_grant", arl_v, 2'b10);
    check("sim_dready", dl_o.d_ready, 1'b1);
    check("sim_c1b", outl, 2'd1);
    tick();
    dl_i.d_valid    = 1'b0;
    hl_i[1].a_valid = 1'b0;
    #1;
    check("sim_c_after", outl, 2'd1);

    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
